// File: rtl/lsu_mem_access_if.sv
// Valid/ready memory bus between the load/store unit and data memory.
// The LSU side is the master; the memory side is the slave.
interface lsu_mem_access_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_wen;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic [3:0]            mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_wen,
    output mem_req_addr,
    output mem_req_wdata,
    output mem_req_wmask,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_wen,
    input  mem_req_addr,
    input  mem_req_wdata,
    input  mem_req_wmask,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_rdata
  );
endinterface

// File: rtl/lsu_mem_access.sv
// Memory-stage LSU: one bus request per op, stalls the pipe until done.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_access #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic                      ex_mem_ren,
  input  logic                      ex_mem_wen,
  input  logic [2:0]                ex_funct3,
  input  logic [ADDR_WIDTH-1:0]     ex_addr,
  input  logic [DATA_WIDTH-1:0]     ex_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      lsu_stall,
  output logic [DATA_WIDTH-1:0]     lsu_rdata,
  output logic                      lsu_rdata_valid,
  output logic [REG_ADDR_WIDTH-1:0] lsu_rd,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                      lsu_misalign,
  output logic [ADDR_WIDTH-1:0]     lsu_fault_addr,
`endif
  lsu_mem_access_if.master          mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [2:0]                f3_q, f3_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                      ld_q, ld_d;
  logic                      new_op;
  logic                      mis_op;
  logic                      mis_q, mis_d;
  logic [DATA_WIDTH-1:0]     load_val;
  logic [DATA_WIDTH-1:0]     sh_b;
  logic [DATA_WIDTH-1:0]     sh_h;
  logic                      sx;

  // Undefined size codes fall through to word.
  function automatic logic is_b(input logic [2:0] f);
    return f[1:0] == 2'b00;
  endfunction

  function automatic logic is_h(input logic [2:0] f);
    return f[1:0] == 2'b01;
  endfunction

  assign new_op = ex_valid & (ex_mem_ren | ex_mem_wen);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_op = (is_h(ex_funct3) & ex_addr[0])
                | (~is_b(ex_funct3) & ~is_h(ex_funct3)
                   & (|ex_addr[1:0]));
`else
  assign mis_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      ld_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (new_op) state_d = mis_op ? DONE : REQ;
      end
      REQ: begin
        if (mem.mem_req_ready) state_d = ld_q ? WAIT : DONE;
      end
      WAIT: begin
        if (mem.mem_resp_valid) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select: bytes use addr[1:0], halves use addr[1] only.
  assign sh_b = mem.mem_resp_rdata >> {addr_q[1:0], 3'b000};
  assign sh_h = mem.mem_resp_rdata >> {addr_q[1], 4'b0000};
  assign sx   = ~f3_q[2];

  always_comb begin
    load_val = mem.mem_resp_rdata;
    unique case (1'b1)
      is_b(f3_q): load_val = {{24{sx & sh_b[7]}}, sh_b[7:0]};
      is_h(f3_q): load_val = {{16{sx & sh_h[15]}}, sh_h[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    ld_d    = ld_q;
    mis_d   = mis_q;
    if (state_q == IDLE && new_op) begin
      addr_d  = ex_addr;
      wdata_d = ex_wdata;
      f3_d    = ex_funct3;
      rd_d    = ex_rd;
      ld_d    = ex_mem_ren;
      mis_d   = mis_op;
    end
    if (state_q == WAIT && mem.mem_resp_valid) begin
      rdata_d = load_val;
    end
  end

  assign lsu_rdata = rdata_q;
  assign lsu_rd    = rd_q;

  always_comb begin
    lsu_stall = (state_q == REQ) | (state_q == WAIT)
              | ((state_q == IDLE) & new_op);
    lsu_rdata_valid   = (state_q == DONE) & ld_q & ~mis_q;
    mem.mem_req_valid = (state_q == REQ);
    mem.mem_req_wen   = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_wdata = '0;
    mem.mem_req_wmask = 4'b0000;
    if (state_q == REQ) begin
      mem.mem_req_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      if (!ld_q) begin
        mem.mem_req_wen = 1'b1;
        unique case (1'b1)
          is_b(f3_q): begin
            mem.mem_req_wmask = 4'b0001 << addr_q[1:0];
            mem.mem_req_wdata = {4{wdata_q[7:0]}};
          end
          is_h(f3_q): begin
            mem.mem_req_wmask = 4'b0011 << {addr_q[1], 1'b0};
            mem.mem_req_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem.mem_req_wmask = 4'b1111;
            mem.mem_req_wdata = wdata_q;
          end
        endcase
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign lsu_misalign   = (state_q == DONE) & mis_q;
  assign lsu_fault_addr = lsu_misalign ? addr_q : '0;
`endif

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with a one-cycle-latency memory.
// Covers load/store alignment, backpressure, reset abort and trap.
module tb_lsu_mem_access;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_mem_ren;
  logic        ex_mem_wen;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_stall;
  logic [31:0] lsu_rdata;
  logic        lsu_rdata_valid;
  logic [4:0]  lsu_rd;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        lsu_misalign;
  logic [31:0] lsu_fault_addr;
`endif

  lsu_mem_access_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem ();

  lsu_mem_access #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_mem_ren     (ex_mem_ren),
    .ex_mem_wen     (ex_mem_wen),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .ex_rd          (ex_rd),
    .lsu_stall      (lsu_stall),
    .lsu_rdata      (lsu_rdata),
    .lsu_rdata_valid(lsu_rdata_valid),
    .lsu_rd         (lsu_rd),
`ifdef LSU_MISALIGN_TRAP_EN
    .lsu_misalign   (lsu_misalign),
    .lsu_fault_addr (lsu_fault_addr),
`endif
    .mem            (mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          o_stall;
  int          o_pulses;
  int          o_hs;
  int          o_reqcyc;
  int          o_unstable;
  logic        o_fin;
  logic [31:0] o_rdata;
  logic [4:0]  o_rd;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wmask;
  logic        o_wen;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at posedge+1; drives one op and plays the memory side.
  task automatic run_op(input logic ren, input logic wen,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] resp, input int delay,
                        input logic spur);
    logic        hs_prev;
    logic        seen;
    int          req_seen;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  m0;
    logic        w0;
    o_stall = 0; o_pulses = 0; o_hs = 0; o_reqcyc = 0;
    o_unstable = 0; o_fin = 1'b0;
    o_rdata = '0; o_rd = '0; o_addr = '0; o_wdata = '0;
    o_wmask = '0; o_wen = 1'b0;
    hs_prev = 1'b0; seen = 1'b0; req_seen = 0;
    a0 = '0; d0 = '0; m0 = '0; w0 = 1'b0;
    ex_valid = 1'b1; ex_mem_ren = ren; ex_mem_wen = wen;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    for (int c = 0; c < 40 && !o_fin; c++) begin
      mem.mem_req_ready  = (req_seen >= delay);
      mem.mem_resp_valid = hs_prev && ren;
      mem.mem_resp_rdata = hs_prev ? resp : 32'hBADBADBA;
      if (spur && req_seen == 1) mem.mem_resp_valid = 1'b1;
      #1;
      hs_prev = 1'b0;
      if (lsu_stall) begin
        o_stall++;
        seen = 1'b1;
      end
      if (lsu_rdata_valid) begin
        o_pulses++;
        o_rdata = lsu_rdata;
        o_rd    = lsu_rd;
      end
      if (mem.mem_req_valid) begin
        if (req_seen == 0) begin
          a0 = mem.mem_req_addr;  d0 = mem.mem_req_wdata;
          m0 = mem.mem_req_wmask; w0 = mem.mem_req_wen;
          o_addr = a0; o_wdata = d0; o_wmask = m0; o_wen = w0;
        end else if (mem.mem_req_addr !== a0 || mem.mem_req_wdata !== d0 ||
                     mem.mem_req_wmask !== m0 || mem.mem_req_wen !== w0) begin
          o_unstable++;
        end
        req_seen++;
        o_reqcyc++;
        if (mem.mem_req_ready) begin
          o_hs++;
          hs_prev = 1'b1;
        end
      end
      if (seen && !lsu_stall) o_fin = 1'b1;
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    mem.mem_resp_valid = 1'b0;
    mem.mem_req_ready  = 1'b1;
    chk("op_done", {31'b0, o_fin}, 32'd1);
    repeat (2) begin
      #1;
      if (lsu_rdata_valid) o_pulses++;
      if (lsu_stall) o_stall++;
      if (mem.mem_req_valid && mem.mem_req_ready) o_hs++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_ren = 1'b0; ex_mem_wen = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    mem.mem_req_ready = 1'b0;
    mem.mem_resp_valid = 1'b0;
    mem.mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst_rvalid", {31'b0, lsu_rdata_valid}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_reqv", {31'b0, mem.mem_req_valid}, 32'd0);
    chk("rst_wmask", {28'b0, mem.mem_req_wmask}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW aligned
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd5,
           32'hDEAD_BEEF, 0, 1'b0);
    chk("lw_addr", o_addr, 32'h8000_0004);
    chk("lw_stall", o_stall, 32'd3);
    chk("lw_pulses", o_pulses, 32'd1);
    chk("lw_rdata", o_rdata, 32'hDEAD_BEEF);
    chk("lw_rd", {27'b0, o_rd}, 32'd5);
    chk("lw_wen", {31'b0, o_wen}, 32'd0);
    chk("lw_wmask", {28'b0, o_wmask}, 32'd0);
    chk("lw_hs", o_hs, 32'd1);

    run_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd6,
           32'h80FF_0102, 0, 1'b0);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb_addr", o_addr, 32'h8000_0000);

    run_op(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 5'd6,
           32'h80FF_0102, 0, 1'b0);
    chk("lbu_rdata", o_rdata, 32'h0000_0080);

    run_op(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 5'd8,
           32'h80FF_0102, 0, 1'b0);
    chk("lh_rdata", o_rdata, 32'hFFFF_80FF);

    run_op(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 5'd8,
           32'h80FF_0102, 0, 1'b0);
    chk("lhu_rdata", o_rdata, 32'h0000_80FF);

    run_op(1'b1, 1'b0, 3'b011, 32'h8000_0024, 32'h0, 5'd4,
           32'hCAFE_F00D, 0, 1'b0);
    chk("f3_011_rdata", o_rdata, 32'hCAFE_F00D);

    // SH upper half
    run_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 5'd0,
           32'h0, 0, 1'b0);
    chk("sh_wmask", {28'b0, o_wmask}, 32'hC);
    chk("sh_wdata", o_wdata, 32'h1234_1234);
    chk("sh_wen", {31'b0, o_wen}, 32'd1);
    chk("sh_stall", o_stall, 32'd2);
    chk("sh_pulses", o_pulses, 32'd0);
    chk("sh_addr", o_addr, 32'h8000_0000);

    run_op(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'hFFFF_FFAB, 5'd0,
           32'h0, 0, 1'b0);
    chk("sb_wmask", {28'b0, o_wmask}, 32'h2);
    chk("sb_wdata", o_wdata, 32'hABAB_ABAB);

`ifndef LSU_MISALIGN_TRAP_EN
    run_op(1'b0, 1'b1, 3'b010, 32'h8000_0013, 32'h0102_0304, 5'd0,
           32'h0, 0, 1'b0);
    chk("sw_mis_addr", o_addr, 32'h8000_0010);
    chk("sw_mis_wmask", {28'b0, o_wmask}, 32'hF);
    chk("sw_mis_wdata", o_wdata, 32'h0102_0304);
`endif

    // ren and wen together act as a load
    run_op(1'b1, 1'b1, 3'b010, 32'h8000_0020, 32'hFFFF_FFFF, 5'd3,
           32'h0F0F_0F0F, 0, 1'b0);
    chk("rw_wen", {31'b0, o_wen}, 32'd0);
    chk("rw_wmask", {28'b0, o_wmask}, 32'd0);
    chk("rw_rdata", o_rdata, 32'h0F0F_0F0F);
    chk("rw_pulses", o_pulses, 32'd1);

    // Backpressure with a spurious response in REQ
    run_op(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd11,
           32'h1357_9BDF, 4, 1'b1);
    chk("bp_stall", o_stall, 32'd7);
    chk("bp_reqcyc", o_reqcyc, 32'd5);
    chk("bp_unstable", o_unstable, 32'd0);
    chk("bp_hs", o_hs, 32'd1);
    chk("bp_pulses", o_pulses, 32'd1);
    chk("bp_rdata", o_rdata, 32'h1357_9BDF);
    chk("bp_rd", {27'b0, o_rd}, 32'd11);

    // Reset while waiting for the response
    ex_valid = 1'b1; ex_mem_ren = 1'b1; ex_mem_wen = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h8000_0008; ex_rd = 5'd7;
    mem.mem_req_ready = 1'b1; mem.mem_resp_valid = 1'b0;
    #1;
    chk("ra_stall0", {31'b0, lsu_stall}, 32'd1);
    @(posedge clk); #1;
    chk("ra_reqv", {31'b0, mem.mem_req_valid}, 32'd1);
    @(posedge clk); #1;
    chk("ra_wait_stall", {31'b0, lsu_stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ex_valid = 1'b0;
    mem.mem_resp_valid = 1'b1;
    mem.mem_resp_rdata = 32'h55AA_55AA;
    #1;
    chk("ra_stall", {31'b0, lsu_stall}, 32'd0);
    chk("ra_rdata", lsu_rdata, 32'd0);
    chk("ra_rd", {27'b0, lsu_rd}, 32'd0);
    chk("ra_reqv0", {31'b0, mem.mem_req_valid}, 32'd0);
    chk("ra_rvalid", {31'b0, lsu_rdata_valid}, 32'd0);
    @(posedge clk); #1;
    mem.mem_resp_valid = 1'b0;
    #1;
    chk("ra_rvalid2", {31'b0, lsu_rdata_valid}, 32'd0);
    chk("ra_rdata2", lsu_rdata, 32'd0);
    @(posedge clk); #1;

    run_op(1'b1, 1'b0, 3'b010, 32'h8000_000C, 32'h0, 5'd9,
           32'h0123_4567, 0, 1'b0);
    chk("post_rdata", o_rdata, 32'h0123_4567);
    chk("post_pulses", o_pulses, 32'd1);
    chk("post_stall", o_stall, 32'd3);

`ifdef LSU_MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_mem_ren = 1'b1; ex_mem_wen = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h8000_0002; ex_rd = 5'd3;
    #1;
    chk("mis_stall0", {31'b0, lsu_stall}, 32'd1);
    chk("mis_reqv0", {31'b0, mem.mem_req_valid}, 32'd0);
    @(posedge clk); #1;
    chk("mis_stall1", {31'b0, lsu_stall}, 32'd0);
    chk("mis_flag", {31'b0, lsu_misalign}, 32'd1);
    chk("mis_addr", lsu_fault_addr, 32'h8000_0002);
    chk("mis_rvalid", {31'b0, lsu_rdata_valid}, 32'd0);
    chk("mis_reqv1", {31'b0, mem.mem_req_valid}, 32'd0);
    ex_valid = 1'b0;
    @(posedge clk); #1;
    chk("mis_clear", {31'b0, lsu_misalign}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Memory-stage load/store unit for the npc pipeline. It services the load/store that the load-use stall logic waits on.
- Takes the EX/MEM operation and issues one request on a valid/ready memory bus. For loads, it waits for the response, then aligns and extends the data.
- Holds `lsu_stall` high, freezing PC, IF/ID, ID/EX and EX/MEM, until the access completes.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; only 32 supported
- REG_ADDR_WIDTH, 5, destination register index width (`REG_ADDR_WIDTH`)

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  reset, synchronous, active-high
- ex_valid  input  1  EX/MEM holds a valid instruction
- ex_mem_ren  input  1  instruction is a load
- ex_mem_wen  input  1  instruction is a store
- ex_funct3  input  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  input  ADDR_WIDTH  byte address
- ex_wdata  input  DATA_WIDTH  store data, right-justified
- ex_rd  input  REG_ADDR_WIDTH  load destination register
- lsu_stall  output  1  pipeline freeze request
- lsu_rdata  output  DATA_WIDTH  aligned and extended load result
- lsu_rdata_valid  output  1  one-cycle pulse; `lsu_rdata`/`lsu_rd` valid
- lsu_rd  output  REG_ADDR_WIDTH  destination register of the returned load
- mem_req_valid  output  1  request valid
- mem_req_ready  input  1  request accepted when valid & ready
- mem_req_wen  output  1  1 = write
- mem_req_addr  output  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- mem_req_wdata  output  DATA_WIDTH  lane-replicated store data
- mem_req_wmask  output  4  byte strobes
- mem_resp_valid  input  1  read data valid
- mem_resp_rdata  input  DATA_WIDTH  read word

Behaviour:
- Reset values: state IDLE; all outputs 0.
- Reset has priority over every transition. It aborts any REQ or WAIT; `mem_req_valid` drops the next cycle. A late `mem_resp_valid` after reset is ignored.
- New op condition: `new_op` = `ex_valid` & (`ex_mem_ren` | `ex_mem_wen`). If ren and wen are both 1, the op is a load and the store is suppressed.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on `new_op`, latch addr, wdata, funct3, rd and type; go to REQ.
  - REQ: `mem_req_valid` = 1; all request fields held stable until handshake. `mem_resp_valid` is ignored here. On handshake, a store goes to DONE and a load goes to WAIT.
  - WAIT: on `mem_resp_valid`, extract the lane selected by addr[1:0], sign- or zero-extend per funct3, register it into `lsu_rdata`; go to DONE.
  - DONE: `lsu_rdata_valid` = 1 for loads only; go to IDLE. DONE never accepts an op, so the still-frozen EX/MEM op is not reissued.
- `lsu_stall` = (state == REQ) | (state == WAIT) | (state == IDLE & `new_op`). It is combinational and is 0 in DONE so the pipeline advances.
- Minimum latency, with ready=1 and response one cycle after accept:
  - load: stall high 3 cycles, data valid in cycle 3
  - store: stall high 2 cycles
- Store strobes and data:
  - SB: wmask = 1 << addr[1:0]; wdata = {4{b}}
  - SH: wmask = 4'b0011 << {addr[1],1'b0}; wdata = {2{h}}
  - SW: wmask = 4'b1111
- Loads always issue wmask = 0.
- Misalignment without the optional feature: offset bits below the access size are ignored.
  - H uses addr[1] only.
  - W ignores addr[1:0].
- Undefined funct3 codes (011, 11x) are treated as W.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds outputs `lsu_misalign` (1) and `lsu_fault_addr` (ADDR_WIDTH).
  - Misaligned condition: H with addr[0] = 1, or W with addr[1:0] != 0.
  - A misaligned op is latched in IDLE and goes directly to DONE. No bus request is made.
  - In DONE: `lsu_misalign` = 1, `lsu_fault_addr` = latched address, `lsu_rdata_valid` = 0.
- When undefined: the ports are absent and misaligned ops behave as described in Behaviour.

Test Plan:
- LW at 0x80000004; ready=1; response 0xDEADBEEF one cycle later → `mem_req_addr` = 0x80000004, stall high exactly 3 cycles, `lsu_rdata` = 0xDEADBEEF pulsed once with `lsu_rd` = `ex_rd`.
- LB at 0x80000003, response 0x80FF0102 → `lsu_rdata` = 0xFFFFFF80. Same with LBU → 0x00000080. LH at addr[1] = 1 → 0xFFFF80FF.
- SH at 0x80000002, wdata 0x1234 → wmask 4'b1100, wdata 0x12341234, wen = 1. Stall high 2 cycles; no `lsu_rdata_valid`.
- `mem_req_ready` low for 4 cycles → `mem_req_valid` and all request fields stable for 4 cycles. Stall stays high. A spurious `mem_resp_valid` during REQ is ignored.
- `rst` asserted during WAIT, then `mem_resp_valid` → state IDLE, all outputs 0, no `lsu_rdata_valid` pulse. The next op is issued normally.
- With LSU_MISALIGN_TRAP_EN: LW at 0x80000002 → no `mem_req_valid`; one-cycle stall, then `lsu_misalign` = 1 with `lsu_fault_addr` = 0x80000002.
